hdmi_rx_period_decoder: RTL and testbench
=========================================

HDMI_RX_PERIOD_DECODER -- requirements
Module: hdmi_rx_period_decoder

Interface
REQ-001 SHALL have parameter PREAMBLE_MIN, default 8: minimum count of consecutive identical preamble cycles before a guard band is accepted.
REQ-002 SHALL have parameter MAX_PACKETS, default 18: maximum packets per data island.
REQ-003 SHALL have port clk_pixel  input  1  pixel/symbol clock, the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tmds_blue, tmds_green, tmds_red  input  10 each  word-aligned, deskewed TMDS symbols for channels 0/1/2, one per clock, bit 0 first-transmitted.
REQ-006 SHALL have port mode  output  3  0 control, 1 video data, 2 video guard, 3 data island, 4 data island guard.
REQ-007 SHALL have port rgb  output  24  {red, green, blue} decoded video bytes.
REQ-008 SHALL have port data_island_data  output  12  {red, green, blue} TERC4 nibbles.
REQ-009 SHALL have port control_data  output  6  {red, green, blue} 2-bit control tokens; [1:0] = {vsync, hsync}.
REQ-010 SHALL have port packet_start  output  1  pulse on the first symbol of each 32-symbol packet.
REQ-011 SHALL have port decode_error  output  1  one-cycle pulse on a protocol violation.

Function
REQ-012 All outputs SHALL be registered, with latency 1 cycle from symbol input to its classification and decode.
REQ-013 Control tokens SHALL be 00=0x354, 01=0x0AB, 10=0x154, 11=0x2AB.
REQ-014 Video decode: d = q[9] ? ~q[7:0] : q[7:0]; out[0]=d[0]; out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]) for i=1..7.
REQ-015 TERC4 0..F SHALL map from 0x29C,0x263,0x2E4,0x2E2,0x171,0x11E,0x18E,0x13C,0x2CC,0x139,0x19C,0x2C6,0x28E,0x271,0x163,0x2C3.
REQ-016 Video guard SHALL be blue=red=0x2CC, green=0x133; data island guard SHALL be green=red=0x133 with blue a TERC4 nibble whose bits[3:2]=11.
REQ-017 FSM states SHALL be CONTROL, VID_GUARD, VID_DATA, DI_LEAD_GUARD, DI_DATA, DI_TRAIL_GUARD.
REQ-018 CONTROL, all three symbols control tokens: the block SHALL output mode=0 and update control_data. The preamble counter SHALL increment (saturating at PREAMBLE_MIN) while {red,green} = {00,01} (video) or {01,01} (island) is unchanged, and SHALL reload to 1 on a pattern change and to 0 on any other pattern.
REQ-019 CONTROL to VID_GUARD (resp. DI_LEAD_GUARD) SHALL occur on a matching guard symbol when counter==PREAMBLE_MIN and the pattern is video (resp. island); otherwise a guard symbol SHALL raise decode_error and the block SHALL stay in CONTROL with the counter at 0.
REQ-020 Each guard state SHALL last exactly 2 symbols (mode 2 or 4). A mismatching second symbol SHALL raise decode_error and go to CONTROL.
REQ-021 VID_DATA: the block SHALL output mode=1 and update rgb. When all three channels carry control tokens, that symbol SHALL be treated in CONTROL. When only some channels carry control tokens, the block SHALL raise decode_error and go to CONTROL.
REQ-022 DI_DATA: the block SHALL output mode=3, update data_island_data, and keep a 5-bit symbol index mod 32. packet_start SHALL be 1 when the index==0.
REQ-023 At a packet boundary (index==0, at least 1 packet done), the DI trailing guard symbol SHALL transition to DI_TRAIL_GUARD. After 2 symbols the block SHALL go to CONTROL with the counter at 0.
REQ-024 A non-TERC4 symbol in DI_DATA SHALL raise decode_error and go to CONTROL.
REQ-025 A boundary after MAX_PACKETS packets without a trailing guard SHALL raise decode_error and go to CONTROL.
REQ-026 A symbol invalid for the current state SHALL raise decode_error with mode=0.
REQ-027 rgb, data_island_data and control_data SHALL hold their last values outside their own periods.

Reset
REQ-028 On reset: state=CONTROL, counter=0, index=0, packet count=0, mode=0, rgb=0, data_island_data=0, control_data=0, packet_start=0, decode_error=0.
REQ-029 Reset SHALL take priority over every other event, including mid-period. A guard arriving immediately after reset SHALL raise decode_error.

Verification
REQ-030 Reset, then 12 cycles of all channels=0x354 -> mode=0, control_data=0, no error.
REQ-031 Video sequence -> mode 0,2,2,1,1,0:
- 8 cycles of green=0x0AB, red=blue=0x354;
- 2 video guard symbols;
- pixel 1: all=0x100; pixel 2: all=0x1FF;
- then control tokens.
Required: rgb=0x000000 after pixel 1 and 0x010101 after pixel 2.
REQ-032 Data island sequence -> mode 4,4, then 3 for 32 cycles, then 4,4,0; packet_start only on data symbol 0; data_island_data=0x000; no error:
- 8 cycles of green=red=0x0AB;
- 2 cycles of blue=0x2C3, green=red=0x133;
- 32 cycles of all=0x29C;
- 2 cycles of trailing guard.
REQ-033 5 video preamble cycles, then a video guard -> decode_error=1 for exactly 1 cycle, mode=0.
REQ-034 Inside DI_DATA, inject blue=0x3FF -> decode_error pulse, mode=0 the next cycle.
REQ-035 Reset at DI symbol 10, then an immediate DI guard -> all outputs at reset values, then decode_error on the guard.

Source files
------------

// File: rtl/hdmi_rx_period_decoder.sv
// hdmi_rx_period_decoder: classifies aligned TMDS symbols into HDMI periods and decodes them.
module hdmi_rx_period_decoder #(
  parameter int PREAMBLE_MIN = 8,
  parameter int MAX_PACKETS = 18
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [9:0]  tmds_blue,
  input  logic [9:0]  tmds_green,
  input  logic [9:0]  tmds_red,
  output logic [2:0]  mode,
  output logic [23:0] rgb,
  output logic [11:0] data_island_data,
  output logic [5:0]  control_data,
  output logic        packet_start,
  output logic        decode_error
);
  localparam int CW = $clog2(PREAMBLE_MIN + 1);
  localparam int PW = $clog2(MAX_PACKETS + 1);
  localparam logic [CW-1:0] PMAX = CW'(PREAMBLE_MIN);
  localparam logic [PW-1:0] PKMAX = PW'(MAX_PACKETS);
  localparam logic [9:0] TERC [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
                                       10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};
  typedef enum logic [2:0] {CONTROL, VID_GUARD, VID_DATA, DI_LEAD_GUARD, DI_DATA, DI_TRAIL_GUARD} state_t;
  state_t state;
  logic [CW-1:0] cnt, cnt_next;
  logic island_pat;
  logic [4:0] idx;
  logic [PW-1:0] pkts;
  logic [2:0] c_b, c_g, c_r;
  logic [4:0] t_b, t_g, t_r;
  logic all_ctl, any_ctl, all_terc, pat_vid, pat_di, vid_guard, di_guard, take_ctl;
  function automatic logic [2:0] ctl_dec(input logic [9:0] q);
    return q == 10'h354 ? 3'b100 : q == 10'h0AB ? 3'b101 : q == 10'h154 ? 3'b110 : q == 10'h2AB ? 3'b111 : 3'b000;
  endfunction
  function automatic logic [4:0] terc_dec(input logic [9:0] q);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (q == TERC[i]) r = {1'b1, 4'(i)};
    return r;
  endfunction
  function automatic logic [7:0] vid_dec(input logic [9:0] q);
    logic [7:0] d;
    d = q[9] ? ~q[7:0] : q[7:0];
    return {d[7:1] ^ d[6:0] ^ {7{~q[8]}}, d[0]};
  endfunction
  assign c_b = ctl_dec(tmds_blue);
  assign c_g = ctl_dec(tmds_green);
  assign c_r = ctl_dec(tmds_red);
  assign t_b = terc_dec(tmds_blue);
  assign t_g = terc_dec(tmds_green);
  assign t_r = terc_dec(tmds_red);
  assign all_ctl = c_b[2] & c_g[2] & c_r[2];
  assign any_ctl = c_b[2] | c_g[2] | c_r[2];
  assign all_terc = t_b[4] & t_g[4] & t_r[4];
  assign pat_vid = all_ctl && c_r[1:0] == 2'b00 && c_g[1:0] == 2'b01;
  assign pat_di = all_ctl && c_r[1:0] == 2'b01 && c_g[1:0] == 2'b01;
  assign vid_guard = tmds_blue == 10'h2CC && tmds_green == 10'h133 && tmds_red == 10'h2CC;
  assign di_guard = tmds_green == 10'h133 && tmds_red == 10'h133 && t_b[4] && t_b[3:2] == 2'b11;
  // A fully-control symbol inside video ends the video period and counts as preamble.
  assign take_ctl = all_ctl && (state == CONTROL || state == VID_DATA);
  assign cnt_next = (pat_vid | pat_di)
                  ? ((cnt != '0 && pat_di == island_pat) ? (cnt == PMAX ? cnt : cnt + 1'b1) : CW'(1))
                  : '0;
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state <= CONTROL;
      cnt <= '0;
      island_pat <= 1'b0;
      idx <= '0;
      pkts <= '0;
      mode <= '0;
      rgb <= '0;
      data_island_data <= '0;
      control_data <= '0;
      packet_start <= 1'b0;
      decode_error <= 1'b0;
    end else begin
      mode <= 3'd0;
      packet_start <= 1'b0;
      decode_error <= 1'b0;
      if (take_ctl) begin
        control_data <= {c_r[1:0], c_g[1:0], c_b[1:0]};
        cnt <= cnt_next;
        island_pat <= pat_di;
        state <= CONTROL;
      end else begin
        state <= CONTROL;
        cnt <= '0;
        decode_error <= 1'b1;
        case (state)
          CONTROL: begin
            if (vid_guard && cnt == PMAX && !island_pat) begin
              state <= VID_GUARD;
              mode <= 3'd2;
              decode_error <= 1'b0;
            end else if (di_guard && cnt == PMAX && island_pat) begin
              state <= DI_LEAD_GUARD;
              mode <= 3'd4;
              decode_error <= 1'b0;
            end
          end
          VID_GUARD: if (vid_guard) begin
            state <= VID_DATA;
            mode <= 3'd2;
            decode_error <= 1'b0;
          end
          VID_DATA: if (!any_ctl) begin
            state <= VID_DATA;
            mode <= 3'd1;
            rgb <= {vid_dec(tmds_red), vid_dec(tmds_green), vid_dec(tmds_blue)};
            decode_error <= 1'b0;
          end
          DI_LEAD_GUARD: if (di_guard) begin
            state <= DI_DATA;
            mode <= 3'd4;
            idx <= '0;
            pkts <= '0;
            decode_error <= 1'b0;
          end
          DI_DATA: begin
            if (idx == '0 && pkts != '0 && di_guard) begin
              state <= DI_TRAIL_GUARD;
              mode <= 3'd4;
              decode_error <= 1'b0;
            end else if (all_terc && !(idx == '0 && pkts == PKMAX)) begin
              state <= DI_DATA;
              mode <= 3'd3;
              data_island_data <= {t_r[3:0], t_g[3:0], t_b[3:0]};
              packet_start <= idx == '0;
              idx <= idx + 5'd1;
              pkts <= idx == 5'd31 ? pkts + 1'b1 : pkts;
              decode_error <= 1'b0;
            end
          end
          DI_TRAIL_GUARD: if (di_guard) begin
            mode <= 3'd4;
            decode_error <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hdmi_rx_period_decoder.sv
// tb_hdmi_rx_period_decoder: randomized period sequences checked through an expectation queue.
module tb_hdmi_rx_period_decoder;
  localparam int PMIN = 8;
  localparam int MAXP = 18;
  logic clk_pixel = 1'b0;
  logic reset = 1'b1;
  logic [9:0] tmds_blue = 10'h354, tmds_green = 10'h354, tmds_red = 10'h354;
  logic [2:0] mode;
  logic [23:0] rgb;
  logic [11:0] data_island_data;
  logic [5:0] control_data;
  logic packet_start, decode_error;
  typedef struct packed {
    logic [2:0] m;
    logic [23:0] rgb;
    logic [11:0] did;
    logic [5:0] cd;
    logic ps;
    logic err;
  } exp_t;
  exp_t q[$];
  exp_t got, want;
  int checks = 0, errors = 0;
  logic [23:0] e_rgb = '0;
  logic [11:0] e_did = '0;
  logic [5:0] e_cd = '0;
  logic [9:0] CTL [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  logic [9:0] TERC [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
                            10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};

  hdmi_rx_period_decoder #(.PREAMBLE_MIN(PMIN), .MAX_PACKETS(MAXP)) dut (
    .clk_pixel(clk_pixel), .reset(reset),
    .tmds_blue(tmds_blue), .tmds_green(tmds_green), .tmds_red(tmds_red),
    .mode(mode), .rgb(rgb), .data_island_data(data_island_data), .control_data(control_data),
    .packet_start(packet_start), .decode_error(decode_error)
  );

  always #5 clk_pixel = ~clk_pixel;

  function automatic logic [7:0] vdec(input logic [9:0] s);
    logic [7:0] d, r;
    d = s[9] ? ~s[7:0] : s[7:0];
    r[0] = d[0];
    for (int i = 1; i < 8; i++) r[i] = s[8] ? (d[i] != d[i-1]) : (d[i] == d[i-1]);
    return r;
  endfunction

  function automatic bit is_ctl(input logic [9:0] s);
    for (int i = 0; i < 4; i++) if (s == CTL[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [9:0] rpix();
    logic [9:0] s;
    do s = 10'($urandom_range(0, 1023)); while (is_ctl(s));
    return s;
  endfunction

  task automatic emit(input logic [9:0] b, g, r, input logic rst, input logic [2:0] m, input logic ps, er);
    exp_t e;
    @(negedge clk_pixel);
    tmds_blue = b;
    tmds_green = g;
    tmds_red = r;
    reset = rst;
    e.m = m;
    e.rgb = e_rgb;
    e.did = e_did;
    e.cd = e_cd;
    e.ps = ps;
    e.err = er;
    q.push_back(e);
  endtask

  task automatic rst_cycle();
    e_rgb = '0;
    e_did = '0;
    e_cd = '0;
    emit(10'($urandom_range(0, 1023)), 10'h133, 10'h133, 1'b1, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic ctl(input int b, g, r);
    e_cd = {2'(r), 2'(g), 2'(b)};
    emit(CTL[b], CTL[g], CTL[r], 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic rctl();
    ctl($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic preamble(input bit island, input int n);
    repeat (n) ctl($urandom_range(0, 3), 1, island ? 1 : 0);
  endtask

  task automatic vguard();
    emit(10'h2CC, 10'h133, 10'h2CC, 1'b0, 3'd2, 1'b0, 1'b0);
  endtask

  task automatic dguard();
    emit(TERC[$urandom_range(12, 15)], 10'h133, 10'h133, 1'b0, 3'd4, 1'b0, 1'b0);
  endtask

  task automatic pixel(input logic [9:0] b, g, r);
    e_rgb = {vdec(r), vdec(g), vdec(b)};
    emit(b, g, r, 1'b0, 3'd1, 1'b0, 1'b0);
  endtask

  task automatic dsym(input int b, g, r, input bit ps);
    e_did = {4'(r), 4'(g), 4'(b)};
    emit(TERC[b], TERC[g], TERC[r], 1'b0, 3'd3, ps, 1'b0);
  endtask

  task automatic dpackets(input int k);
    for (int i = 0; i < k; i++) dsym($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), i % 32 == 0);
  endtask

  task automatic bad(input logic [9:0] b, g, r);
    emit(b, g, r, 1'b0, 3'd0, 1'b0, 1'b1);
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk_pixel);
      #1;
      if (q.size() > 0) begin
        want = q.pop_front();
        got = {mode, rgb, data_island_data, control_data, packet_start, decode_error};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL symbol %0d: got mode=%0d rgb=%h did=%h cd=%h ps=%b err=%b, expected mode=%0d rgb=%h did=%h cd=%h ps=%b err=%b",
                   checks, got.m, got.rgb, got.did, got.cd, got.ps, got.err,
                   want.m, want.rgb, want.did, want.cd, want.ps, want.err);
        end
      end
    end
  end

  initial begin : stimulus
    repeat (2) rst_cycle();
    repeat (12) ctl(0, 0, 0);
    repeat (8) ctl(0, 1, 0);
    vguard();
    vguard();
    pixel(10'h100, 10'h100, 10'h100);
    pixel(10'h1FF, 10'h1FF, 10'h1FF);
    ctl(0, 0, 0);
    repeat (8) ctl(0, 1, 1);
    repeat (2) emit(10'h2C3, 10'h133, 10'h133, 1'b0, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) dsym(0, 0, 0, i == 0);
    repeat (2) emit(10'h2C3, 10'h133, 10'h133, 1'b0, 3'd4, 1'b0, 1'b0);
    ctl(0, 0, 0);
    repeat (5) ctl(0, 1, 0);
    bad(10'h2CC, 10'h133, 10'h2CC);
    ctl(0, 0, 0);
    preamble(1, PMIN);
    dguard();
    dguard();
    dpackets(5);
    bad(10'h3FF, TERC[0], TERC[0]);
    ctl(0, 0, 0);
    preamble(1, PMIN);
    dguard();
    dguard();
    dpackets(10);
    rst_cycle();
    bad(TERC[12], 10'h133, 10'h133);
    ctl(0, 0, 0);
    preamble(1, PMIN + 2);
    dguard();
    dguard();
    dpackets(MAXP * 32);
    bad(TERC[3], TERC[5], TERC[7]);
    ctl(0, 0, 0);
    repeat (60) begin
      case ($urandom_range(0, 6))
        0: repeat ($urandom_range(1, 6)) rctl();
        1: begin
          preamble(0, $urandom_range(PMIN, PMIN + 3));
          vguard();
          vguard();
          repeat ($urandom_range(1, 8)) pixel(rpix(), rpix(), rpix());
          rctl();
        end
        2: begin
          preamble(1, $urandom_range(PMIN, PMIN + 3));
          dguard();
          dguard();
          dpackets(32 * $urandom_range(1, 3));
          dguard();
          dguard();
          rctl();
        end
        3: begin
          ctl($urandom_range(0, 3), 3, $urandom_range(0, 3));
          if ($urandom_range(0, 1) == 1) begin
            preamble(1, $urandom_range(1, PMIN - 1));
            bad(TERC[$urandom_range(12, 15)], 10'h133, 10'h133);
          end else begin
            preamble(0, $urandom_range(1, PMIN - 1));
            bad(10'h2CC, 10'h133, 10'h2CC);
          end
          rctl();
        end
        4: begin
          preamble(0, PMIN);
          vguard();
          vguard();
          repeat ($urandom_range(1, 4)) pixel(rpix(), rpix(), rpix());
          bad(CTL[$urandom_range(0, 3)], rpix(), rpix());
          rctl();
        end
        5: begin
          preamble(1, PMIN);
          dguard();
          dguard();
          dpackets($urandom_range(1, 40));
          bad(TERC[$urandom_range(0, 15)], 10'h3FF, TERC[$urandom_range(0, 15)]);
          rctl();
        end
        default: begin
          preamble(0, PMIN);
          vguard();
          bad(10'h3FF, 10'h133, 10'h2CC);
          rctl();
        end
      endcase
    end
    ctl(0, 0, 0);
    repeat (3) @(posedge clk_pixel);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
